// File: rtl/register_bus_master.sv
// Bus addresses shared with configuration_registers, followed by the host-side
// initiator that sequences read/write cycles on the configuration-register bus.
package registers_pkg;
    localparam logic [2:0] LDVR_ADDR = 3'd4;
    localparam logic [2:0] UDVR_ADDR = 3'd5;
endpackage

module register_bus_master
    import registers_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic        cmd_wide_i,
    input  logic [2:0]  cmd_address_i,
    input  logic [15:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        read_o,
    output logic        write_o,
    output logic [2:0]  address_o,
    inout  wire  [7:0]  data_io
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        HOLD,
        RD_LO,
        RD_HI,
        RESP
    } state_t;

    state_t      state, state_next;
    logic        wide_q, wide_next;
    logic [7:0]  data_hi_q, data_hi_next;
    logic [7:0]  wdata_q, wdata_next;
    logic        read_next;
    logic        write_next;
    logic [2:0]  address_next;
    logic        rsp_valid_next;
    logic [15:0] rsp_data_next;

    assign cmd_ready_o = (state == IDLE);

    // Output enable is the registered write strobe, so the bus is released
    // in every cycle that is not a write cycle, including HOLD.
    assign data_io = write_o ? wdata_q : 'z;

    // Next-state and next-output decode. Bus outputs are computed from the
    // state being entered so they are registered yet aligned with that state.
    always_comb begin
        state_next     = state;
        wide_next      = wide_q;
        data_hi_next   = data_hi_q;
        wdata_next     = wdata_q;
        read_next      = 1'b0;
        write_next     = 1'b0;
        address_next   = address_o;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_o;

        unique case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    wide_next    = cmd_wide_i;
                    data_hi_next = cmd_data_i[15:8];
                    address_next = cmd_wide_i ? LDVR_ADDR : cmd_address_i;
                    if (cmd_write_i) begin
                        state_next = WR_LO;
                        write_next = 1'b1;
                        wdata_next = cmd_data_i[7:0];
                    end else begin
                        state_next = RD_LO;
                        read_next  = 1'b1;
                    end
                end
            end
            WR_LO: begin
                if (wide_q) begin
                    state_next   = WR_HI;
                    write_next   = 1'b1;
                    address_next = UDVR_ADDR;
                    wdata_next   = data_hi_q;
                end else begin
                    state_next     = HOLD;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = '0;
                end
            end
            WR_HI: begin
                state_next     = HOLD;
                rsp_valid_next = 1'b1;
                rsp_data_next  = '0;
            end
            HOLD: begin
                state_next = IDLE;
            end
            RD_LO: begin
                rsp_data_next = {8'h00, data_io};
                if (wide_q) begin
                    state_next   = RD_HI;
                    read_next    = 1'b1;
                    address_next = UDVR_ADDR;
                end else begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                end
            end
            RD_HI: begin
                rsp_data_next[15:8] = data_io;
                state_next          = RESP;
                rsp_valid_next      = 1'b1;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched command and registered bus/response outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            wide_q      <= 1'b0;
            data_hi_q   <= '0;
            wdata_q     <= '0;
            read_o      <= 1'b0;
            write_o     <= 1'b0;
            address_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            state       <= state_next;
            wide_q      <= wide_next;
            data_hi_q   <= data_hi_next;
            wdata_q     <= wdata_next;
            read_o      <= read_next;
            write_o     <= write_next;
            address_o   <= address_next;
            rsp_valid_o <= rsp_valid_next;
            rsp_data_o  <= rsp_data_next;
        end
    end

endmodule

// File: tb/tb_register_bus_master.sv
// Directed bench for register_bus_master with a simple register-bus slave model.
module tb_register_bus_master;
    import registers_pkg::*;

    localparam logic [2:0] TXR_ADDR = 3'd0;
    localparam logic [2:0] RXR_ADDR = 3'd0;
    localparam logic [2:0] STR_ADDR = 3'd1;

    typedef struct {
        logic        write;
        logic        wide;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_rsp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_wide;
    logic [2:0]  cmd_address;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        read_s;
    logic        write_s;
    logic [2:0]  address;
    wire  [7:0]  data_bus;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Slave model
    logic [7:0] regs [8];
    logic [7:0] fifo [4];
    int         pops = 0;
    int         tx_writes = 0;
    logic [7:0] slave_val;
    logic [15:0] rsp_hist [$];

    register_bus_master dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_wide_i   (cmd_wide),
        .cmd_address_i(cmd_address),
        .cmd_data_i   (cmd_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .read_o       (read_s),
        .write_o      (write_s),
        .address_o    (address),
        .data_io      (data_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign slave_val = (address == RXR_ADDR) ? fifo[pops % 4] : regs[address];
    assign data_bus  = read_s ? slave_val : 8'hzz;

    always @(posedge clk) begin
        if (write_s) begin
            if (address == TXR_ADDR) tx_writes <= tx_writes + 1;
            else if (address != STR_ADDR) regs[address] <= data_bus;
        end
        if (read_s && address == RXR_ADDR) pops <= pops + 1;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Strobe-exclusion and bus-ownership monitor
    always @(negedge clk) begin
        if (rst_n && (read_s || write_s)) begin
            chk("strobe_overlap", {15'd0, read_s && write_s}, 16'd0);
            if (read_s) chk("read_bus_owner", {8'd0, data_bus}, {8'd0, slave_val});
        end
        if (rst_n && rsp_valid) rsp_hist.push_back(rsp_data);
    end

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready_timeout"}, {15'd0, n < 20}, 16'd1);
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        logic [2:0] a0;
        string      nm;
        nm = $sformatf("v%0d", idx);
        a0 = v.wide ? LDVR_ADDR : v.addr;
        @(negedge clk);
        cmd_write   = v.write;
        cmd_wide    = v.wide;
        cmd_address = v.addr;
        cmd_data    = v.data;
        cmd_valid   = 1'b1;
        wait_ready(nm);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_strobe1"}, {14'd0, read_s, write_s}, v.write ? 16'd1 : 16'd2);
        chk({nm, "_addr1"}, {13'd0, address}, {13'd0, a0});
        chk({nm, "_rsp_early1"}, {15'd0, rsp_valid}, 16'd0);
        if (v.write) chk({nm, "_wdata1"}, {8'd0, data_bus}, {8'd0, v.data[7:0]});
        if (v.wide) begin
            @(negedge clk);
            chk({nm, "_strobe2"}, {14'd0, read_s, write_s}, v.write ? 16'd1 : 16'd2);
            chk({nm, "_addr2"}, {13'd0, address}, {13'd0, UDVR_ADDR});
            chk({nm, "_rsp_early2"}, {15'd0, rsp_valid}, 16'd0);
            if (v.write) chk({nm, "_wdata2"}, {8'd0, data_bus}, {8'd0, v.data[15:8]});
        end
        @(negedge clk);
        chk({nm, "_rsp_valid"}, {15'd0, rsp_valid}, 16'd1);
        chk({nm, "_rsp_data"}, rsp_data, v.exp_rsp);
        chk({nm, "_strobe_off"}, {14'd0, read_s, write_s}, 16'd0);
        if (v.write) chk({nm, "_hold_addr"}, {13'd0, address}, v.wide ? {13'd0, UDVR_ADDR} : {13'd0, a0});
        @(negedge clk);
        chk({nm, "_ready_after"}, {15'd0, cmd_ready}, 16'd1);
        chk({nm, "_rsp_pulse"}, {15'd0, rsp_valid}, 16'd0);
    endtask

    vec_t vecs [11];
    int   edges [3];

    initial begin
        for (int unsigned i = 0; i < 8; i++) regs[i] = 8'h00;
        regs[STR_ADDR] = 8'hA7;
        regs[7]        = 8'h3C;
        fifo[0] = 8'h11; fifo[1] = 8'h22; fifo[2] = 8'h33; fifo[3] = 8'h44;

        //          write wide addr      data      exp_rsp
        vecs[0]  = '{1'b1, 1'b0, TXR_ADDR, 16'h005A, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 3'd0,     16'h1234, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, STR_ADDR, 16'h0000, 16'h00A7};
        vecs[3]  = '{1'b0, 1'b1, 3'd0,     16'h0000, 16'h1234};
        vecs[4]  = '{1'b0, 1'b0, RXR_ADDR, 16'h0000, 16'h0011};
        vecs[5]  = '{1'b0, 1'b0, RXR_ADDR, 16'h0000, 16'h0022};
        vecs[6]  = '{1'b1, 1'b0, 3'd6,     16'hFFC3, 16'h0000};
        vecs[7]  = '{1'b0, 1'b0, 3'd6,     16'h0000, 16'h00C3};
        vecs[8]  = '{1'b1, 1'b1, 3'd7,     16'hBEEF, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 3'd7,     16'h0000, 16'hBEEF};
        vecs[10] = '{1'b0, 1'b0, 3'd7,     16'h0000, 16'h003C};

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wide = 1'b0;
        cmd_address = '0; cmd_data = '0;
        rst_n = 1'b0;
        #12;
        chk("reset_ready", {15'd0, cmd_ready}, 16'd1);
        chk("reset_strobes", {14'd0, read_s, write_s}, 16'd0);
        chk("reset_addr", {13'd0, address}, 16'd0);
        chk("reset_rsp", {15'd0, rsp_valid}, 16'd0);
        chk("reset_rsp_data", rsp_data, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_cmd(vecs[i], i);
        chk("tx_fifo_writes", tx_writes[15:0], 16'd1);
        chk("rx_fifo_pops", pops[15:0], 16'd2);

        // Back-to-back write/read/write with cmd_valid held high throughout
        @(negedge clk);
        cmd_write = 1'b1; cmd_wide = 1'b0; cmd_address = 3'd6; cmd_data = 16'h0099;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready($sformatf("b2b%0d", k));
            @(posedge clk);
            #1;
            edges[k] = cyc;
            if (k == 0) begin
                cmd_write = 1'b0; cmd_address = 3'd6; cmd_data = 16'h0000;
            end else if (k == 1) begin
                cmd_write = 1'b1; cmd_address = 3'd7; cmd_data = 16'h0042;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("b2b_gap01", 16'(edges[1] - edges[0]), 16'd3);
        chk("b2b_gap12", 16'(edges[2] - edges[1]), 16'd3);
        chk("b2b_rd_rsp", rsp_hist[rsp_hist.size() - 2], 16'h0099);
        chk("b2b_reg6", {8'd0, regs[6]}, 16'h0099);
        chk("b2b_reg7", {8'd0, regs[7]}, 16'h0042);

        // Reset in the middle of the UDVR cycle of a wide write
        @(negedge clk);
        cmd_write = 1'b1; cmd_wide = 1'b1; cmd_data = 16'h5678; cmd_valid = 1'b1;
        wait_ready("rst_cmd");
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_pre_strobe", {14'd0, read_s, write_s}, 16'd1);
        chk("rst_pre_addr", {13'd0, address}, {13'd0, UDVR_ADDR});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {14'd0, read_s, write_s}, 16'd0);
        chk("rst_mid_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_mid_addr", {13'd0, address}, 16'd0);
        chk("rst_mid_rsp", {15'd0, rsp_valid}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ldvr_written", {8'd0, regs[LDVR_ADDR]}, 16'h0078);
        chk("rst_udvr_kept", {8'd0, regs[UDVR_ADDR]}, 16'h00BE);
        rst_n = 1'b1;

        run_cmd('{1'b0, 1'b1, 3'd0, 16'h0000, 16'hBE78}, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/register_bus_master.md
# register_bus_master

Host-side initiator for the UART configuration-register bus. It accepts byte and 16-bit divisor access commands over a valid/ready handshake and turns them into correctly sequenced `read_o`/`write_o`/`address_o` cycles on the shared tri-state `data_io` bus. It also returns read data and write completions as single-cycle responses. It sits between the system CPU/bridge logic and `configuration_registers`, and guarantees the two bus rules that block depends on:
- the LDVR→UDVR back-to-back divisor write;
- the one-cycle address hold after a write.

## Interface
- No parameters. Bus addresses `LDVR_ADDR` and `UDVR_ADDR` come from `registers_pkg`.
- Reset `rst_n_i` is asynchronous and active-low; the clock is `clk_i`.
- `clk_i  in  1  clock`
- `rst_n_i  in  1  asynchronous active-low reset`
- `cmd_valid_i  in  1  command present; fields stable until accepted`
- `cmd_ready_o  out  1  block can accept a command`
- `cmd_write_i  in  1  1 = write, 0 = read`
- `cmd_wide_i  in  1  1 = 16-bit divisor access; cmd_address_i ignored`
- `cmd_address_i  in  3  register address for byte access`
- `cmd_data_i  in  16  write data; byte access uses [7:0]`
- `rsp_valid_o  out  1  one-cycle pulse: read data valid / write complete`
- `rsp_data_o  out  16  read data; byte read zero-extends, writes return 0`
- `read_o  out  1  bus read strobe`
- `write_o  out  1  bus write strobe`
- `address_o  out  3  bus address`
- `data_io  inout  8  bus data; driven only while write_o = 1, else Z`

## Operation
- FSM states: IDLE, WR_LO, WR_HI, HOLD, RD_LO, RD_HI, RESP. `cmd_ready_o` = 1 only in IDLE.
- Accept: on `cmd_valid_i & cmd_ready_o`, the command is latched. Next state is WR_LO if `cmd_write_i`, else RD_LO.
- WR_LO:
  - `write_o` = 1.
  - `address_o` = `LDVR_ADDR` if wide, else the latched address.
  - drive `data[7:0]`.
  - next state is WR_HI if wide, else HOLD.
- WR_HI: `write_o` = 1, `address_o` = `UDVR_ADDR`, drive `data[15:8]`; next state is HOLD.
- HOLD: `write_o` = 0 and `address_o` unchanged, so the slave's registered TXR write qualifier still sees the address. `rsp_valid_o` = 1, `rsp_data_o` = 0. Next state is IDLE.
- RD_LO:
  - `read_o` = 1.
  - `address_o` = `LDVR_ADDR` if wide, else the latched address.
  - `data_io` is sampled into `rsp_data_o[7:0]` at the closing edge.
  - next state is RD_HI if wide, else RESP (upper byte cleared).
- RD_HI: `read_o` = 1, `address_o` = `UDVR_ADDR`, sample `[15:8]`; next state is RESP.
- RESP: `rsp_valid_o` = 1 with the captured data; next state is IDLE.
- Strobe and bus-drive rules:
  - `read_o` and `write_o` are never both 1.
  - `data_io` is never driven while `read_o` = 1.
  - There are no idle cycles between LDVR and UDVR cycles of a wide access.
- `address_o` holds its last value in IDLE.
- `rsp_data_o` holds its value outside RESP/HOLD, except that HOLD sets it to 0.
- A read of RXR is exactly one `read_o` cycle, so it pops exactly one FIFO entry.

## Timing
- Reset values: state = IDLE, `cmd_ready_o` = 1, `read_o` = 0, `write_o` = 0, `address_o` = 0, `data_io` = Z, `rsp_valid_o` = 0, `rsp_data_o` = 0.
- All bus outputs and `rsp_*` are registered; `data_io` output enable equals registered `write_o`.
- Latency, with accept at edge E:
  - byte write: `write_o` high in cycle E+1, `rsp_valid_o` in E+2, ready in E+3.
  - wide write: strobes in E+1 and E+2, rsp in E+3.
  - byte read: `read_o` in E+1, rsp in E+2.
  - wide read: `read_o` in E+1 and E+2, rsp in E+3.
- Throughput is one byte command per 3 cycles and one wide command per 4 cycles.
- Boundary conditions:
  - `cmd_valid_i` while not ready: the command is held and not lost.
  - `cmd_valid_i` asserted in the same cycle the FSM returns to IDLE is accepted on that edge.
  - Reset mid-operation: immediate return to reset values and bus released. A wide write cut after WR_LO leaves only LDVR written, with no divisor commit; this is accepted behaviour.
- `rsp_valid_o` has no back-pressure; the consumer must take it in that cycle.

## Test plan
- **Reset:** assert `rst_n_i` mid-WR_HI → all strobes 0, `data_io` = Z, `cmd_ready_o` = 1 in the same cycle; LDVR written, UDVR not.
- **Byte write:** addr = TXR, data = 0x5A → `write_o` for 1 cycle with `data_io` = 0x5A; `address_o` = TXR held the next cycle; the slave raises `tx_fifo_write_o` once; `rsp_valid_o` at E+2.
- **Wide write:** 0x1234 → LDVR/0x34 then UDVR/0x12 on consecutive cycles; the slave `divisor_o` becomes 0x1234 after reset-of-baud-gen pulse; rsp at E+3.
- **Byte read:** STR with slave STR = 0xA7 → `read_o` for 1 cycle, `data_io` never driven by the master, `rsp_data_o` = 0x00A7 at E+2.
- **Wide read** after the wide write → `rsp_data_o` = 0x1234. Two RXR reads → exactly two FIFO pops.
- **Back-to-back** write-read-write with `cmd_valid_i` held high → each accepted as soon as IDLE is reached; no strobe overlap or bus contention (`data_io` never X).
